// File: rtl/sp_pkg.sv
// ============================================================================
// sp_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the serial-to-parallel receiver (and the matching
// transmitter model): alignment symbol, lock threshold default, the last bit
// position of a byte, and the receiver state encoding.
// ============================================================================
package sp_pkg;

    // Idle / alignment symbol, transmitted MSB first.
    localparam logic [7:0] COM_DEFAULT       = 8'hBC;

    // Consecutive aligned COMs needed before the receiver declares lock.
    localparam int         COM_COUNT_DEFAULT = 4;

    // bit_cnt value on the cycle that samples the last bit of a byte.
    localparam logic [2:0] BIT_LAST          = 3'd7;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,  // hunting for COM with a sliding window
        SYNC   = 2'd1,  // candidate alignment found, counting aligned COMs
        LOCKED = 2'd2   // aligned; non-COM bytes are delivered downstream
    } sp_state_e;

    // Lock target as a 4-bit count; COM_COUNT is legal in 1..15.
    function automatic logic [3:0] com_target(input int count);
        return 4'(count);
    endfunction

endpackage : sp_pkg

// File: rtl/serial_paralelo_verde_if.sv
// ============================================================================
// serial_paralelo_verde_if
// ----------------------------------------------------------------------------
// Bundles the receiver's serial input and byte-side outputs.
//   data_in   : serial bit stream, MSB of each byte first
//   data_out  : last received non-COM byte, holds between pulses
//   valid_out : one-cycle pulse when data_out is updated
//   active    : high while the receiver is locked
// Modports:
//   master : the link side (drives data_in, observes the byte outputs)
//   slave  : the receiver itself
// ============================================================================
interface serial_paralelo_verde_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface : serial_paralelo_verde_if

// File: rtl/serial_paralelo_verde.sv
// ============================================================================
// serial_paralelo_verde
// ----------------------------------------------------------------------------
// Serial-to-parallel receiver for the bit link. Runs entirely on the serial
// bit clock; byte boundaries come from a 3-bit counter. The receiver hunts for
// the COM symbol with a sliding window, confirms the alignment over COM_COUNT
// consecutive aligned COMs, then delivers every non-COM byte as a one-cycle
// valid pulse. COM bytes seen while locked are idle fill and are dropped.
//
// Ports:
//   clk32_f : serial bit clock, all logic on posedge
//   reset   : asynchronous, active-low reset
//   sp      : serial_paralelo_verde_if.slave (data_in, data_out, valid_out,
//             active)
//
// Parameters:
//   COM_SYMBOL : alignment / idle symbol (default 8'hBC)
//   COM_COUNT  : aligned COMs required to lock, 1..15 (default 4)
//
// Build option:
//   SP_REALIGN_EN : when defined, a COM completing off the byte boundary while
//                   locked is treated as a misalignment; the receiver drops
//                   active and re-synchronises on the new alignment. When
//                   undefined, lock holds until reset.
// ============================================================================
module serial_paralelo_verde
    import sp_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_DEFAULT,
    parameter int         COM_COUNT  = COM_COUNT_DEFAULT
) (
    input  logic                   clk32_f,
    input  logic                   reset,
    serial_paralelo_verde_if.slave sp
);

    localparam logic [3:0] COM_TGT       = com_target(COM_COUNT);
    // With a threshold of one, the first COM found is already enough to lock.
    localparam bit         LOCK_ON_FIRST = (COM_COUNT == 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    sp_state_e  state_q,     state_d;
    // Only the seven youngest bits are ever read back, so only those are kept;
    // the eighth bit of the window is always the incoming data_in.
    logic [6:0] sr_q,        sr_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0] com_cnt_q,   com_cnt_d;
    logic [7:0] data_out_q,  data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       active_q,    active_d;

    // ------------------------------------------------------------------------
    // Window / compare logic shared by next-state and output processes
    // ------------------------------------------------------------------------
    logic [7:0] next_byte;
    logic       com_match;
    logic       boundary;
    logic [3:0] com_cnt_inc;
    logic       sync_done;
    logic       realign;

    assign next_byte   = {sr_q, sp.data_in};
    assign com_match   = (next_byte == COM_SYMBOL);
    assign boundary    = (bit_cnt_q == BIT_LAST);
    assign com_cnt_inc = com_cnt_q + 4'd1;
    assign sync_done   = (com_cnt_inc == COM_TGT);

`ifdef SP_REALIGN_EN
    // A COM completing anywhere but the boundary means the transmitter's byte
    // framing has moved under us.
    assign realign = (state_q == LOCKED) && com_match && !boundary;
`else
    assign realign = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register (all flops)
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk32_f or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (com_match) begin
                    state_d = LOCK_ON_FIRST ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (!com_match) begin
                        state_d = SEARCH;
                    end else if (sync_done) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (realign) begin
                    state_d = LOCK_ON_FIRST ? LOCKED : SYNC;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        sr_d        = next_byte[6:0];
        bit_cnt_d   = bit_cnt_q + 3'd1;   // wraps 7 -> 0 on its own
        com_cnt_d   = com_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;               // pulse only on a delivering boundary
        active_d    = active_q;

        unique case (state_q)
            SEARCH: begin
                // Counter phase is irrelevant until a COM fixes the alignment.
                bit_cnt_d = bit_cnt_q;
                if (com_match) begin
                    bit_cnt_d = '0;
                    com_cnt_d = 4'd1;
                    active_d  = LOCK_ON_FIRST;
                end
            end
            SYNC: begin
                // Off-boundary COM matches are ignored here: a COM straddling
                // the boundary must not restart the count.
                if (boundary) begin
                    if (!com_match) begin
                        com_cnt_d = '0;
                    end else begin
                        com_cnt_d = com_cnt_inc;
                        if (sync_done) begin
                            active_d = 1'b1;
                        end
                    end
                end
            end
            LOCKED: begin
                if (realign) begin
                    bit_cnt_d = '0;
                    com_cnt_d = 4'd1;
                    active_d  = LOCK_ON_FIRST;
                end else if (boundary && !com_match) begin
                    data_out_d  = next_byte;
                    valid_out_d = 1'b1;
                end
            end
            default: begin
                com_cnt_d = '0;
                active_d  = 1'b0;
            end
        endcase
    end

    assign sp.data_out  = data_out_q;
    assign sp.valid_out = valid_out_q;
    assign sp.active    = active_q;

endmodule : serial_paralelo_verde

// File: tb/tb_serial_paralelo_verde.sv
// ============================================================================
// tb_serial_paralelo_verde
// ----------------------------------------------------------------------------
// Directed bench for serial_paralelo_verde with hand-computed expectations.
// Bits are driven on the falling edge and outputs are sampled 1 ns after the
// rising edge that consumed the bit.
// ============================================================================
`timescale 1ns/1ps
module tb_serial_paralelo_verde;

    logic clk32_f = 1'b0;
    logic reset   = 1'b0;

    serial_paralelo_verde_if sp_if ();

    serial_paralelo_verde dut (
        .clk32_f (clk32_f),
        .reset   (reset),
        .sp      (sp_if.slave)
    );

    always #5 clk32_f = ~clk32_f;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Present one bit; returns once the consuming edge has settled.
    task automatic send_bit(input logic b);
        @(negedge clk32_f);
        sp_if.data_in = b;
        @(posedge clk32_f);
        #1;
    endtask

    // Present a byte MSB first. Checks that no pulse occurs before the last
    // bit, and that valid/data after the last bit match expectations.
    task automatic send_byte(input string tag, input logic [7:0] b,
                             input logic exp_valid, input logic [7:0] exp_data);
        int mid_pulses;
        mid_pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i != 0 && sp_if.valid_out) mid_pulses++;
        end
        check({tag, ".mid_pulses"}, 8'(mid_pulses), 8'd0);
        check({tag, ".valid"},      {7'd0, sp_if.valid_out}, {7'd0, exp_valid});
        check({tag, ".data"},       sp_if.data_out, exp_data);
    endtask

    // Send a byte without per-byte checks (used for COM runs).
    task automatic send_raw(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        @(negedge clk32_f);
        reset = 1'b0;
        sp_if.data_in = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        sp_if.data_in = 1'b0;
        reset = 1'b0;
        #12;
        // --- reset state
        check("rst.active", {7'd0, sp_if.active},    8'd0);
        check("rst.valid",  {7'd0, sp_if.valid_out}, 8'd0);
        check("rst.data",   sp_if.data_out,          8'h00);
        @(negedge clk32_f);
        reset = 1'b1;

        // --- aligned COM stream: lock on the 4th COM (bit 32)
        send_byte("com1", 8'hBC, 1'b0, 8'h00);
        send_byte("com2", 8'hBC, 1'b0, 8'h00);
        send_byte("com3", 8'hBC, 1'b0, 8'h00);
        check("align.active_after3", {7'd0, sp_if.active}, 8'd0);
        send_byte("com4", 8'hBC, 1'b0, 8'h00);
        check("align.active_after4", {7'd0, sp_if.active}, 8'd1);

        // --- data delivery; data_out holds between pulses
        send_byte("d_fc", 8'hFC, 1'b1, 8'hFC);
        send_bit(1'b0);  // first bit of 0x5A
        check("hold.valid", {7'd0, sp_if.valid_out}, 8'd0);
        check("hold.data",  sp_if.data_out,          8'hFC);
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h5A;
            send_bit(v[i]);
        end
        check("d_5a.valid", {7'd0, sp_if.valid_out}, 8'd1);
        check("d_5a.data",  sp_if.data_out,          8'h5A);
        send_byte("com_drop", 8'hBC, 1'b0, 8'h5A);

        // --- mid-byte asynchronous reset while locked with data 0xFC
        send_byte("d_fc2", 8'hFC, 1'b1, 8'hFC);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.active", {7'd0, sp_if.active},    8'd0);
        check("midrst.data",   sp_if.data_out,          8'h00);
        check("midrst.valid",  {7'd0, sp_if.valid_out}, 8'd0);
        @(negedge clk32_f);
        reset = 1'b1;

        // --- 3 junk bits then COM stream: lock after 4 whole COMs
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_raw(8'hBC); send_raw(8'hBC); send_raw(8'hBC);
        check("junk.active_after3", {7'd0, sp_if.active}, 8'd0);
        send_raw(8'hBC);
        check("junk.active_after4", {7'd0, sp_if.active}, 8'd1);

        // --- boundary mismatch in SYNC drops back to SEARCH
        do_reset();
        send_raw(8'hBC); send_raw(8'hBC);
        send_raw(8'h00);
        send_raw(8'hBC); send_raw(8'hBC); send_raw(8'hBC);
        check("resync.active_after3", {7'd0, sp_if.active}, 8'd0);
        send_raw(8'hBC);
        check("resync.active_after4", {7'd0, sp_if.active}, 8'd1);
        check("resync.valid",         {7'd0, sp_if.valid_out}, 8'd0);

        // --- one-bit slip while locked: COM completes at bit_cnt = 6
        send_byte("d_a1", 8'hA1, 1'b1, 8'hA1);
        // 0xBC with its leading 1 supplied by the last bit of 0xA1
        begin
            logic [6:0] tail;
            tail = 7'b0111100;
            for (int i = 6; i >= 0; i--) send_bit(tail[i]);
        end
`ifdef SP_REALIGN_EN
        check("slip.active_dropped", {7'd0, sp_if.active}, 8'd0);
        send_raw(8'hBC); send_raw(8'hBC);
        check("slip.active_after2", {7'd0, sp_if.active}, 8'd0);
        send_raw(8'hBC);
        check("slip.relock",        {7'd0, sp_if.active}, 8'd1);
        check("slip.data_held",     sp_if.data_out,       8'hA1);
`else
        check("slip.active_held", {7'd0, sp_if.active}, 8'd1);
        send_raw(8'hBC); send_raw(8'hBC); send_raw(8'hBC);
        check("slip.active_still", {7'd0, sp_if.active}, 8'd1);
        // Old framing now cuts each COM as 0111_1001.
        check("slip.rotated_data", sp_if.data_out,       8'h79);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_paralelo_verde
